testro_pio_poller: RTL and testbench
====================================

// Module: testro_pio_poller
// PURPOSE
//  Avalon-MM read initiator for the 14-bit TestRO input PIO slave (s1).
//  - Reads PIO address 0 every PERIOD clocks.
//  - Pushes each captured sample into a small FIFO.
//  - Presents the FIFO as a valid/ready stream to downstream logic.
//  - Reports dropped samples with a sticky overflow flag.
// PARAMETERS
//  PERIOD   1000  poll interval in clk cycles; legal range >= 3
//  DEPTH    4     FIFO entries; must be a power of 2, >= 2
//  DW       14    sample width, equal to the PIO in_port width
// PORTS
//  clk           in   1   system clock
//  reset_n       in   1   synchronous, active-low reset
//  enable        in   1   1 = polling active
//  avm_address   out  2   PIO address; always 0
//  avm_read      out  1   read strobe; 1-cycle pulse
//  avm_readdata  in   32  PIO read data; fixed read latency of 1, no waitrequest
//  src_data      out  DW  FIFO head sample
//  src_valid     out  1   FIFO not empty
//  src_ready     in   1   downstream accepts; pop when valid & ready
//  overflow      out  1   sticky: a sample was dropped
//  overflow_clr  in   1   clears overflow
// BEHAVIOUR
//  Reset (reset_n=0 at posedge):
//   - avm_read=0, avm_address=0, src_valid=0, src_data=0, overflow=0.
//   - FIFO empty; divider=0; pending=0; FSM=IDLE.
//  Divider:
//   - Counts 0..PERIOD-1 while enable=1; wraps to 0 and asserts tick for 1 cycle.
//   - enable=0: divider held at 0, pending cleared.
//   - An in-flight read still completes while enable=0.
//  Pending:
//   - Set by tick; cleared when the FSM leaves IDLE.
//   - Ticks arriving while pending=1 merge into the one pending request.
//  FSM:
//   - IDLE: if pending, go to READ.
//   - READ: avm_read=1, avm_address=0 for exactly 1 cycle; go to CAPT.
//   - CAPT: sample=avm_readdata[DW-1:0]; bits [31:DW] ignored; push; go to IDLE.
//   - Poll latency, tick to push: 3 cycles.
//  FIFO:
//   - Circular buffer with a log2(DEPTH)+1-bit count; pointers wrap mod DEPTH.
//   - src_data is the head entry, valid in the same cycle src_valid=1.
//   - Pop and push in the same cycle: both happen, count unchanged.
//   - Full and push without pop: sample dropped, FIFO unchanged, overflow=1.
//   - Full with push and pop in the same cycle: push accepted, no overflow.
//   - Pop while empty: ignored.
//   - overflow_clr and a new drop in the same cycle: overflow stays 1.
//  Reset mid-read (reset_n=0 during READ or CAPT):
//   - In-flight sample discarded; FSM returns to IDLE.
// CONFIGURATION
//  Macro TESTRO_POLL_CHANGE_ONLY_EN:
//   - Defined: in CAPT, push only if the sample differs from the last captured
//     sample. The first capture after reset always pushes. The last-sample
//     register updates on every capture, including captures dropped on overflow.
//   - Undefined: every capture is pushed; no last-sample register.
// TESTING
//  1 Reset: hold reset_n=0 for 3 clk -> all outputs 0.
//    Release with enable=0 -> avm_read never asserts.
//  2 PERIOD=8, enable=1, readdata=32'h0000_1ABC, src_ready=1
//    -> avm_read pulses every 8 clk with address=0.
//    -> src_data=14'h1ABC, src_valid=1 three cycles after each tick.
//  3 src_ready=0, DEPTH=4, 5 polls -> 4 entries held; 5th dropped; overflow=1.
//    Then pulse overflow_clr -> overflow=0; drain -> samples in order.
//  4 Full FIFO with src_ready=1 in the capture cycle -> push accepted, overflow=0.
//  5 Assert reset_n=0 during READ -> no push; then restart -> normal polling.
//  6 Macro defined, readdata 5,5,7 -> stream 5,7. Macro undefined -> 5,5,7.

Source files
------------

// File: rtl/testro_pio_poller.sv
// Polls PIO address 0 every PERIOD clocks into a DEPTH-entry valid/ready FIFO. Tick to push takes 3 cycles.
// A full FIFO drops new samples and sets sticky overflow. With TESTRO_POLL_CHANGE_ONLY_EN, only changed samples are pushed.
module testro_pio_poller #(
    parameter int PERIOD = 1000,
    parameter int DEPTH  = 4,
    parameter int DW     = 14
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    output logic [1:0]    avm_address,
    output logic          avm_read,
    input  logic [31:0]   avm_readdata,
    output logic [DW-1:0] src_data,
    output logic          src_valid,
    input  logic          src_ready,
    output logic          overflow,
    input  logic          overflow_clr
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = AW + 1;
    localparam int DIVW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    typedef enum logic [1:0] {IDLE, READ, CAPT} state_t;

    state_t           state_q, state_d;
    logic [DIVW-1:0]  div_q, div_d;
    logic             pending_q, pending_d;
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [DW-1:0]    mem_q [DEPTH];

    logic             tick, capt, push_req, pop, full, do_wr, drop;
    logic [DW-1:0]    sample;
    logic             unused_hi;

    assign sample    = avm_readdata[DW-1:0];
    assign unused_hi = ^avm_readdata[31:DW];
    assign tick      = enable && (div_q == DIVW'(PERIOD - 1));

    always_comb begin
        div_d     = div_q + DIVW'(1);
        pending_d = pending_q;
        if (!enable) begin
            div_d     = '0;
            pending_d = 1'b0;
        end else if (tick) begin
            div_d     = '0;
            pending_d = 1'b1;
        end else if (state_q == IDLE) begin
            pending_d = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        avm_read = 1'b0;
        capt     = 1'b0;
        case (state_q)
            IDLE: if (pending_q) state_d = READ;
            READ: begin
                avm_read = 1'b1;
                state_d  = CAPT;
            end
            CAPT: begin
                capt    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef TESTRO_POLL_CHANGE_ONLY_EN
    logic [DW-1:0] last_q;
    logic          last_vld_q;

    // Last-sample tracks every capture, even one that is later dropped on overflow.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else if (capt) begin
            last_q     <= sample;
            last_vld_q <= 1'b1;
        end
    end

    assign push_req = capt && (!last_vld_q || (sample != last_q));
`else
    assign push_req = capt;
`endif

    assign src_valid   = (count_q != '0);
    assign src_data    = src_valid ? mem_q[rd_q] : '0;
    assign avm_address = 2'b00;
    assign overflow    = ovf_q;
    assign full        = (count_q == CW'(DEPTH));
    assign pop         = src_valid && src_ready;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign do_wr       = push_req && (!full || pop);
    assign drop        = push_req && full && !pop;

    always_comb begin
        count_d = count_q;
        wr_d    = do_wr ? wr_q + AW'(1) : wr_q;
        rd_d    = pop   ? rd_q + AW'(1) : rd_q;
        case ({do_wr, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (drop)              ovf_d = 1'b1;
        else if (overflow_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            div_q     <= '0;
            pending_q <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            pending_q <= pending_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            if (do_wr) mem_q[wr_q] <= sample;
        end
    end

endmodule

// File: tb/tb_testro_pio_poller.sv
// Bench for testro_pio_poller: directed phases plus random traffic against a queue-based poll/FIFO model.
module tb_testro_pio_poller;
    localparam int PERIOD = 8;
    localparam int DEPTH  = 4;
    localparam int DW     = 14;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    avm_address;
    logic          avm_read;
    logic [31:0]   avm_readdata = '0;
    logic [DW-1:0] src_data;
    logic          src_valid;
    logic          src_ready = 1'b0;
    logic          overflow;
    logic          overflow_clr = 1'b0;

    always #5 clk = ~clk;

    testro_pio_poller #(.PERIOD(PERIOD), .DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .overflow(overflow), .overflow_clr(overflow_clr)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int reads_seen = 0;

    // Model: expected FIFO contents, cycle numbers of scheduled captures (tick + 3).
    logic [DW-1:0] mq[$];
    int            caps[$];
    int            en_run = 0;
    bit            m_ovf = 1'b0;
    bit            have_last = 1'b0;
    logic [DW-1:0] last_s = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit exp_read();
        foreach (caps[i]) if (caps[i] == cyc + 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit capture_now();
        return (caps.size() > 0) && (caps[0] == cyc);
    endfunction

    task automatic step();
        bit pop, push, drop;
        logic [DW-1:0] s;
        @(posedge clk);
        if (!reset_n) begin
            mq.delete();
            caps.delete();
            en_run    = 0;
            m_ovf     = 1'b0;
            have_last = 1'b0;
        end else begin
            pop  = (mq.size() > 0) && src_ready;
            push = 1'b0;
            if (capture_now()) begin
                void'(caps.pop_front());
                s = avm_readdata[DW-1:0];
`ifdef TESTRO_POLL_CHANGE_ONLY_EN
                push = !have_last || (s != last_s);
`else
                push = 1'b1;
`endif
                have_last = 1'b1;
                last_s    = s;
            end
            if (enable) begin
                if (en_run % PERIOD == PERIOD - 1) caps.push_back(cyc + 3);
                en_run++;
            end else begin
                en_run = 0;
            end
            drop = push && (mq.size() == DEPTH) && !pop;
            if (pop) void'(mq.pop_front());
            if (push && !drop) mq.push_back(s);
            if (drop) m_ovf = 1'b1;
            else if (overflow_clr) m_ovf = 1'b0;
        end
        cyc++;
        #1;
        if (avm_read === 1'b1) reads_seen++;
        chk("avm_read", {31'b0, avm_read}, {31'b0, exp_read()});
        chk("avm_address", {30'b0, avm_address}, 32'd0);
        chk("src_valid", {31'b0, src_valid}, {31'b0, mq.size() > 0});
        chk("src_data", {{(32-DW){1'b0}}, src_data},
            {{(32-DW){1'b0}}, (mq.size() > 0) ? mq[0] : {DW{1'b0}}});
        chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    endtask

    initial begin
        int vals_n;
        int hits;
        int guard;
        logic [DW-1:0] got6[$];
        int exp6[3];

        // Reset held 3 cycles, then idle with enable low.
        reset_n = 1'b0;
        repeat (3) step();
        chk("rst_valid", {31'b0, src_valid}, 32'd0);
        chk("rst_data", {18'b0, src_data}, 32'd0);
        chk("rst_ovf", {31'b0, overflow}, 32'd0);
        reset_n = 1'b1;
        reads_seen = 0;
        repeat (20) step();
        chk("idle_no_read", reads_seen, 0);

        // Steady polling of a constant value.
        enable = 1'b1;
        src_ready = 1'b1;
        avm_readdata = 32'hFFFF_DABC;
        repeat (16) step();
        reads_seen = 0;
        hits = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (src_valid === 1'b1 && src_data === 14'h1ABC) hits++;
        end
        chk("reads_per_32", reads_seen, 4);
        chk("samples_1abc", hits, 4);

        // Five polls with the sink stalled: fifth is dropped.
        src_ready = 1'b0;
        for (int i = 0; i < 5 * PERIOD; i++) begin
            avm_readdata = $urandom;
            step();
        end
        chk("ovf_set", {31'b0, overflow}, 32'd1);
        enable = 1'b0;
        repeat (4) step();
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        chk("ovf_clr", {31'b0, overflow}, 32'd0);
        src_ready = 1'b1;
        repeat (6) step();
        chk("drained", {31'b0, src_valid}, 32'd0);

        // Full FIFO with a pop in the capture cycle: push taken, no overflow.
        enable = 1'b1;
        src_ready = 1'b0;
        guard = 0;
        while (mq.size() < DEPTH && guard < 100) begin
            avm_readdata = $urandom;
            step();
            guard++;
        end
        chk("fill_timeout", {31'b0, guard >= 100}, 32'd0);
        guard = 0;
        while (!capture_now() && guard < 20) begin
            step();
            guard++;
        end
        chk("capt_timeout", {31'b0, guard >= 20}, 32'd0);
        avm_readdata = $urandom;
        src_ready = 1'b1;
        step();
        src_ready = 1'b0;
        chk("full_pushpop_ovf", {31'b0, overflow}, 32'd0);
        chk("full_pushpop_valid", {31'b0, src_valid}, 32'd1);

        // Reset asserted during the read cycle.
        src_ready = 1'b1;
        guard = 0;
        while (!exp_read() && guard < 20) begin
            step();
            guard++;
        end
        chk("read_timeout", {31'b0, guard >= 20}, 32'd0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (3) step();
        chk("midread_no_push", {31'b0, src_valid}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            avm_readdata = $urandom;
            step();
        end

        // Value sequence 5,5,7 straight after reset.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        src_ready = 1'b0;
        avm_readdata = 32'd5;
        repeat (12) step();
        repeat (8) step();
        avm_readdata = 32'd7;
        repeat (8) step();
        enable = 1'b0;
        repeat (4) step();
        src_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (src_valid === 1'b1) got6.push_back(src_data);
            step();
        end
`ifdef TESTRO_POLL_CHANGE_ONLY_EN
        vals_n = 2;
        exp6[0] = 5; exp6[1] = 7; exp6[2] = 0;
`else
        vals_n = 3;
        exp6[0] = 5; exp6[1] = 5; exp6[2] = 7;
`endif
        chk("seq_len", got6.size(), vals_n);
        for (int i = 0; i < vals_n; i++)
            chk("seq_val", (i < got6.size()) ? {18'b0, got6[i]} : 32'hDEAD, exp6[i]);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            enable       = ($urandom_range(0, 19) != 0);
            src_ready    = ($urandom_range(0, 2) == 0);
            overflow_clr = ($urandom_range(0, 19) == 0);
            avm_readdata = $urandom;
            if ($urandom_range(0, 3) == 0) avm_readdata = {$urandom, 2'b01};
            step();
        end
        overflow_clr = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
